// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Purpose  : Two-port AXI4-Lite read arbiter, round-robin, one outstanding read.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0 (instruction cache)
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [ADDR_WIDTH-1:0] s0_araddr,
  input  logic [2:0]            s0_arprot,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [DATA_WIDTH-1:0] s0_rdata,
  output logic [1:0]            s0_rresp,
  // port 1 (data cache)
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [ADDR_WIDTH-1:0] s1_araddr,
  input  logic [2:0]            s1_arprot,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [DATA_WIDTH-1:0] s1_rdata,
  output logic [1:0]            s1_rresp,
  // memory side
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0] r_state;
  logic       r_grant;
  logic       r_last;

  logic w_any;
  logic w_win;
  logic w_idle;
  logic w_data;

  assign w_any  = s0_arvalid | s1_arvalid;
  // On a tie the port not served last wins; otherwise the lone requester wins.
  assign w_win  = (s0_arvalid && s1_arvalid) ? ~r_last : s1_arvalid;
  assign w_idle = (r_state == IDLE);
  assign w_data = (r_state == DATA);

  // arready is combinational, so it is also gated by reset to stay low then.
  assign s0_arready = reset && w_idle && s0_arvalid && !w_win;
  assign s1_arready = reset && w_idle && s1_arvalid &&  w_win;

  assign m_arvalid = (r_state == ADDR);
  assign m_rready  = w_data && (r_grant ? s1_rready : s0_rready);

  assign s0_rvalid = w_data && !r_grant && m_rvalid;
  assign s1_rvalid = w_data &&  r_grant && m_rvalid;
  assign s0_rdata  = (w_data && !r_grant) ? m_rdata : '0;
  assign s1_rdata  = (w_data &&  r_grant) ? m_rdata : '0;
  assign s0_rresp  = (w_data && !r_grant) ? m_rresp : 2'b00;
  assign s1_rresp  = (w_data &&  r_grant) ? m_rresp : 2'b00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      m_araddr <= '0;
      m_arprot <= 3'b000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            m_araddr <= w_win ? s1_araddr : s0_araddr;
            m_arprot <= w_win ? s1_arprot : s0_arprot;
            r_grant  <= w_win;
            r_last   <= w_win;
            r_state  <= ADDR;
          end
        end
        ADDR: begin
          if (m_arready) r_state <= DATA;
        end
        DATA: begin
          if (m_rvalid && m_rready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Two-port AXI4-Lite read-channel arbiter that lets the instruction cache (port 0) and the data cache (port 1) share one memory read interface. It accepts one read address at a time from the winning requester, replays it on the memory side, and routes the single read response back to that requester. Arbitration is round-robin and allows only one outstanding transaction. The block sits between the two cache refill engines and the memory/interconnect read slave.

## Interface
- ADDR_WIDTH, 32, read address width
- DATA_WIDTH, 32, read data width
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- s0_arvalid / s1_arvalid  in  1  requester address valid (port 0 = i_cache, port 1 = d_cache)
- s0_arready / s1_arready  out  1  requester address accepted
- s0_araddr / s1_araddr  in  ADDR_WIDTH  requester read address
- s0_arprot / s1_arprot  in  3  requester protection bits
- s0_rvalid / s1_rvalid  out  1  response valid to requester
- s0_rready / s1_rready  in  1  requester ready for response
- s0_rdata / s1_rdata  out  DATA_WIDTH  response data
- s0_rresp / s1_rresp  out  2  response code
- m_arvalid  out  1  memory address valid
- m_arready  in  1  memory address ready
- m_araddr  out  ADDR_WIDTH  memory read address (registered)
- m_arprot  out  3  memory protection bits (registered)
- m_rvalid  in  1  memory response valid
- m_rready  out  1  memory response ready
- m_rdata  in  DATA_WIDTH  memory read data
- m_rresp  in  2  memory response code

## Operation
- States: IDLE, ADDR, DATA; plus 1-bit `grant` (port being served) and 1-bit `last` (port served most recently).
- IDLE: winner = only requester with arvalid; if both, winner = !last. s<winner>_arready = 1 combinationally in IDLE (0 for loser and in all other states). On that handshake: latch araddr/arprot into m_araddr/m_arprot, grant <= winner, last <= winner, state -> ADDR. No arvalid: stay IDLE.
- ADDR: m_arvalid = 1; hold m_araddr/m_arprot stable. On m_arready: state -> DATA.
- DATA: m_rready = s<grant>_rready; s<grant>_rvalid = m_rvalid; s<grant>_rdata/rresp = m_rdata/m_rresp. Non-granted rvalid = 0. On m_rvalid && m_rready: state -> IDLE.
- rdata/rresp to non-granted port driven 0. rresp passed unmodified (SLVERR/DECERR not interpreted).
- Requester arvalid raised while the arbiter is busy is held pending (AXI rule: requester keeps arvalid and address stable until arready).
- Reset (async, any state): state = IDLE, m_arvalid = 0, m_rready = 0, all s*_arready/s*_rvalid = 0, m_araddr = 0, m_arprot = 0, grant = 0, last = 1 (port 0 wins the first tie). An in-flight transaction is abandoned; no response is forwarded after reset.

## Timing
- Address path: requester handshake in cycle N -> m_arvalid high in cycle N+1 (1-cycle latency, registered).
- Response path: combinational pass-through m_r* -> s<grant>_r* and s<grant>_rready -> m_rready in DATA, zero added latency.
- Back-to-back: response handshake in cycle M returns to IDLE at M+1; next address accept earliest at M+1. Minimum transaction spacing is therefore address accept + 1 + memory AR wait + R wait + 1.
- m_arvalid never drops before m_arready; m_araddr constant while m_arvalid = 1.
- Simultaneous s0/s1 arvalid in IDLE: exactly one arready, chosen by round-robin; loser served next transaction if still requesting.
- m_rvalid in IDLE/ADDR is ignored (m_rready = 0).

## Test plan
- Reset then s0 only reads 0x0000_1000; memory returns 0xDEAD_BEEF, rresp 0 -> s0_arready one cycle, m_araddr 0x1000 at N+1, s0_rdata 0xDEADBEEF, s1_rvalid stays 0.
- s0 and s1 assert arvalid in the same cycle (0x100, 0x200) and hold -> first m_araddr 0x100 (port 0), second 0x200 (port 1); rdata routed to correct port.
- s1 requests continuously, s0 requests continuously for 4 transactions -> grants alternate 0,1,0,1.
- Memory holds m_arready low 5 cycles, then s1_rready low 3 cycles with m_rvalid high -> m_arvalid/m_araddr stable throughout; m_rready follows s1_rready; single transfer completes.
- m_rresp = 2'b10 with rdata 0x1234 -> requester sees rresp 2'b10, rdata 0x1234, arbiter returns to IDLE.
- Assert reset (0) while in DATA with m_rvalid low -> all outputs at reset values asynchronously; after release, s1-only request is accepted normally and no stale response appears.
